uart_tx_serializer: RTL
=======================

# uart_tx_serializer

Byte-to-serial transmitter for the lab's 8-bit serial link. It accepts one byte per valid/ready handshake from the datapath and drives it onto a single output line as an asynchronous frame: start bit, 8 data bits LSB first, optional even parity, then 1 or 2 stop bits. It sits at the sending end of the link that the lab's one-bit serial input ports consume, and it produces the line those ports sample.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal range is 2 or more. The bit counter width is `$clog2(CLKS_PER_BIT)`.
- `PARITY_EN`, default 0: when 1, an even-parity bit is inserted after data bit 7.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.
- `clk`, input, 1: the single clock. All state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `tx_valid`, input, 1: the datapath has a byte to send.
- `tx_data`, input, 8: the byte. It is sampled only on the accepting edge.
- `tx_ready`, output, 1: the block can accept a byte. High only in IDLE. Decoded from state, with no dependence on `tx_valid`.
- `txd`, output, 1: serial line. Idles high. Registered, so glitch-free.
- `busy`, output, 1: equal to `~tx_ready`.

## Operation
- States and transitions:
  - IDLE → START on `tx_valid & tx_ready`. On that edge `tx_data` is latched into the shift register, parity is computed as the XOR of the 8 bits, and the bit counter is cleared.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → PARITY after 8 bits if `PARITY_EN`, otherwise DATA → STOP.
  - PARITY → STOP after one bit time.
  - STOP → IDLE after `STOP_BITS` bit times.
- Line level per state: START drives 0, DATA drives the shift register LSB, PARITY drives the parity bit, STOP and IDLE drive 1.
- Shift register: shifts right once at the end of each data bit time. A bit index of 0–7 counts data bits.
- Input stability: changes to `tx_data` or `tx_valid` while busy have no effect. The latched byte alone is transmitted.
- Reset values, asserted asynchronously while `rst_n`=0: state=IDLE, `txd`=1, `tx_ready`=1, `busy`=0, counters=0, shift register=0.
- Reset mid-frame: `txd` returns to 1 immediately, without waiting for a clock. The partial frame is abandoned and not resumed. The first edge after release can accept a new byte.
- Even parity: the parity bit equals the XOR of the data bits, so the total number of ones over data plus parity is even.

## Timing
- Let k be the accepting edge, F = 1 + 8 + `PARITY_EN` + `STOP_BITS`, and N = `CLKS_PER_BIT`.
- `txd` falls to 0 after edge k. `tx_ready` drops after edge k.
- Bit i of the frame (i = 0 is start) is driven after edge k + i·N and held for exactly N cycles.
- After edge k + F·N: state=IDLE, `tx_ready`=1, `txd`=1.
- Back-to-back: with `tx_valid` held high, the next accept happens at edge k + F·N + 1. This guarantees exactly 1 idle-high cycle between frames, so the frame period is F·N + 1 cycles.
- `tx_valid` asserted during a frame is neither lost nor queued early. It is accepted on the first edge where `tx_ready`=1.
- Bit timing uses a single down-counter reloaded with N−1 at each bit boundary. There is no drift across the frame: the total is exactly F·N cycles.

## Test plan
- **Reset state:** hold `rst_n`=0 for 3 cycles, then release. Require `txd`=1, `tx_ready`=1, `busy`=0. Then idle 20 cycles with `tx_valid`=0 and require `txd` to stay 1.
- **Single byte, default framing:** N=4, PARITY_EN=0, STOP_BITS=1. Send 0xA5. Require `txd` to be 0,1,0,1,0,0,1,0,1,1, each held exactly 4 cycles. Require `tx_ready` to be high again exactly 40 cycles after the accept.
- **Parity:** N=4, PARITY_EN=1. Send 0x07, then 0xA5. Require the parity bit to be 1 for 0x07 and 0 for 0xA5. Require frame length F=11, i.e. 44 cycles.
- **Two stop bits and back-to-back:** STOP_BITS=2, N=4. Hold `tx_valid`=1 with 0x3C, then 0xC3. Require 2 stop bits (8 cycles high) plus 1 idle cycle between frames. Require the second frame to carry 0xC3 LSB first.
- **Data change while busy:** accept 0x55. Then change `tx_data` to 0xFF mid-frame and toggle `tx_valid`. Require the serialized bits to match 0x55 and no extra frame to start before `tx_ready` returns.
- **Reset mid-frame:** assert `rst_n`=0 during data bit 3. Require `txd`=1 before the next clock edge. After release, send 0x81 and require a clean full frame.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// Byte-to-serial UART transmitter: start bit, 8 data bits LSB first, optional
// even parity, 1 or 2 stop bits. The line is registered and idles high.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       txd,
  output logic       busy
);

  // state  | meaning
  // IDLE   | line high, ready for a byte
  // START  | driving start bit (0)
  // DATA   | driving shift register LSB, 8 bit times
  // PARITY | driving even parity bit
  // STOP   | driving stop bit(s) (1)
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    idx, idx_nx;
  logic          stop_idx, stop_nx;
  logic [7:0]    sh, sh_nx;
  logic          par, par_nx;
  logic          line_nx;
  logic          tick;

  assign tick     = (cnt == '0);
  assign tx_ready = (state == IDLE);
  assign busy     = ~tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      stop_idx <= 1'b0;
      sh       <= '0;
      par      <= 1'b0;
      txd      <= 1'b1;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      idx      <= idx_nx;
      stop_idx <= stop_nx;
      sh       <= sh_nx;
      par      <= par_nx;
      txd      <= line_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    stop_nx  = stop_idx;
    sh_nx    = sh;
    par_nx   = par;
    line_nx  = 1'b1;

    // one down-counter paces every bit; reload at each boundary keeps frames drift-free
    if (state != IDLE) begin
      cnt_nx = tick ? RELOAD : cnt - 1'b1;
    end

    case (state)
      IDLE: begin
        if (tx_valid) begin
          state_nx = START;
          sh_nx    = tx_data;
          par_nx   = ^tx_data;
          idx_nx   = '0;
          stop_nx  = 1'b0;
          cnt_nx   = RELOAD;
        end
      end
      START: begin
        if (tick) state_nx = DATA;
      end
      DATA: begin
        if (tick) begin
          sh_nx = {1'b0, sh[7:1]};
          if (idx == 3'd7) begin
            state_nx = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_nx = idx + 3'd1;
          end
        end
      end
      PARITY: begin
        if (tick) state_nx = STOP;
      end
      STOP: begin
        if (tick) begin
          if (stop_idx == LAST_STOP) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else begin
            stop_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    // line level follows the state being entered so txd comes straight from a flop
    case (state_nx)
      START:   line_nx = 1'b0;
      DATA:    line_nx = sh_nx[0];
      PARITY:  line_nx = par_nx;
      default: line_nx = 1'b1;
    endcase
  end

endmodule
